// File: rtl/clk_mon_pkg.sv
// Shared types and default ratios for the divided-clock period monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_EXP_WPER = 4;
  localparam int DEF_EXP_RPER = 6;
  localparam int DEF_TOL      = 0;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_TIMEOUT  = 64;

endpackage

// File: rtl/clk_period_meter.sv
// One channel: synchronise a divided clock, time its period in clk cycles,
// and track lock/error against the expected ratio.
module clk_period_meter
  import clk_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int EXP      = DEF_EXP_WPER,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             err_clr,
  input  logic             div_clk,
  output logic [CNT_W-1:0] per,
  output logic             per_valid,
  output logic             lock,
  output logic             err
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0]   EXP_X = (CNT_W + 1)'(EXP);
  localparam logic [CNT_W:0]   TOL_X = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0]  MC_LAST = MC_W'(LOCK_CNT - 1);

  logic s1, s2, s3;
  logic rise;
  logic [CNT_W-1:0] cnt;
  logic [MC_W-1:0]  match_cnt;
  mon_state_t state;

  logic [CNT_W:0] cnt_x;
  logic [CNT_W:0] diff;
  logic match;
  logic tmo;
  logic err_set;

  assign rise  = s2 & ~s3;
  assign cnt_x = {1'b0, cnt};

  always_comb begin
    diff  = (cnt_x >= EXP_X) ? cnt_x - EXP_X : EXP_X - cnt_x;
    match = diff <= TOL_X;
  end

  // A missing edge only counts as a fault once the channel had locked.
  assign tmo     = ~rise & (cnt == TMO_C);
  assign err_set = en & (state == LOCKED) & ((rise & ~match) | tmo);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      match_cnt <= '0;
      state     <= ACQ;
      per       <= '0;
      per_valid <= 1'b0;
      lock      <= 1'b0;
      err       <= 1'b0;
    end else begin
      s1        <= div_clk;
      s2        <= s1;
      s3        <= s2;
      per_valid <= 1'b0;

      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;

      if (!en) begin
        state     <= ACQ;
        cnt       <= '0;
        match_cnt <= '0;
        lock      <= 1'b0;
      end else begin
        if (rise)
          cnt <= CNT_W'(1);
        else if (cnt != '1)
          cnt <= cnt + 1'b1;

        unique case (state)
          ACQ: begin
            if (rise)
              state <= TRACK;
          end
          TRACK: begin
            if (rise) begin
              per       <= cnt;
              per_valid <= 1'b1;
              if (!match) begin
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
                if (match_cnt == MC_LAST) begin
                  state <= LOCKED;
                  lock  <= 1'b1;
                end
              end
            end else if (tmo) begin
              match_cnt <= '0;
              state     <= ACQ;
            end
          end
          LOCKED: begin
            if (rise) begin
              per       <= cnt;
              per_valid <= 1'b1;
              if (!match) begin
                lock      <= 1'b0;
                match_cnt <= '0;
                state     <= TRACK;
              end
            end else if (tmo) begin
              lock      <= 1'b0;
              match_cnt <= '0;
              state     <= ACQ;
            end
          end
          default: state <= ACQ;
        endcase
      end
    end
  end

endmodule

// File: rtl/clk_ratio_monitor.sv
// Write/read divided-clock checker: one period meter per channel,
// shared enable and error clear.
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int EXP_WPER = DEF_EXP_WPER,
  parameter int EXP_RPER = DEF_EXP_RPER,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             err_clr,
  input  logic             wclk_in,
  input  logic             rclk_in,
  output logic [CNT_W-1:0] wper,
  output logic             wper_valid,
  output logic             wlock,
  output logic             werr,
  output logic [CNT_W-1:0] rper,
  output logic             rper_valid,
  output logic             rlock,
  output logic             rerr
);

  clk_period_meter #(
    .CNT_W    (CNT_W),
    .EXP      (EXP_WPER),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT),
    .TIMEOUT  (TIMEOUT)
  ) u_wmeter (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .err_clr   (err_clr),
    .div_clk   (wclk_in),
    .per       (wper),
    .per_valid (wper_valid),
    .lock      (wlock),
    .err       (werr)
  );

  clk_period_meter #(
    .CNT_W    (CNT_W),
    .EXP      (EXP_RPER),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT),
    .TIMEOUT  (TIMEOUT)
  ) u_rmeter (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .err_clr   (err_clr),
    .div_clk   (rclk_in),
    .per       (rper),
    .per_valid (rper_valid),
    .lock      (rlock),
    .err       (rerr)
  );

endmodule
